sdram_host_queue: RTL

Request queue and sequencer placed directly upstream of the SDRAM controller's single-word host port. Accepts read/write requests over a valid/ready handshake, buffers them in a small FIFO, and issues them one at a time as single-cycle `rd_enable`/`wr_enable` pulses. It confirms each request was accepted by watching `busy`, and reissues any request that was dropped during init or refresh. Read data is returned through a one-entry response register with valid/ready.

---
 rtl/sdram_host_queue.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sdram_host_queue.sv
// Request FIFO and one-at-a-time sequencer in front of a single-word SDRAM host port.
// Issues single-cycle enable pulses and reissues any pulse that busy never acknowledged.
module sdram_host_queue #(
  parameter int ADDR_WIDTH  = 24,
  parameter int DEPTH       = 4,
  parameter int ACCEPT_WAIT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [15:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [15:0]           resp_data,
  output logic [ADDR_WIDTH-1:0] ctrl_wr_addr,
  output logic [15:0]           ctrl_wr_data,
  output logic                  ctrl_wr_enable,
  output logic [ADDR_WIDTH-1:0] ctrl_rd_addr,
  output logic                  ctrl_rd_enable,
  input  logic [15:0]           ctrl_rd_data,
  input  logic                  ctrl_rd_ready,
  input  logic                  ctrl_busy,
  output logic [7:0]            stat_retries
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int WAIT_W = $clog2(ACCEPT_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_ACCEPT,
    S_DONE
  } state_t;

  logic                  r_mem_write [DEPTH];
  logic [ADDR_WIDTH-1:0] r_mem_addr  [DEPTH];
  logic [15:0]           r_mem_wdata [DEPTH];

  logic [PTR_W:0]        r_wr_ptr;
  logic [PTR_W:0]        r_rd_ptr;
  state_t                r_state;
  state_t                w_state_next;
  logic [WAIT_W-1:0]     r_wait;
  logic                  r_resp_valid;
  logic [15:0]           r_resp_data;
  logic [7:0]            r_retries;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_head_write;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [15:0]           w_head_wdata;
  logic                  w_retry;
  logic                  w_resp_load;
  logic                  w_wait_clr;
  logic                  w_wait_inc;
  logic                  w_resp_free;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

  assign req_ready = rst_n && !w_full;
  assign w_push    = req_valid && req_ready;

  assign w_head_write = !w_empty && r_mem_write[r_rd_ptr[PTR_W-1:0]];
  assign w_head_addr  = w_empty ? '0 : r_mem_addr[r_rd_ptr[PTR_W-1:0]];
  assign w_head_wdata = w_empty ? '0 : r_mem_wdata[r_rd_ptr[PTR_W-1:0]];

  assign ctrl_wr_addr = w_head_addr;
  assign ctrl_rd_addr = w_head_addr;
  assign ctrl_wr_data = w_head_wdata;

  assign resp_valid   = r_resp_valid;
  assign resp_data    = r_resp_data;
  assign stat_retries = r_retries;

  // A read may start only if the response slot is empty or being drained now.
  assign w_resp_free = !r_resp_valid || resp_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_write[r_wr_ptr[PTR_W-1:0]] <= req_write;
      r_mem_addr[r_wr_ptr[PTR_W-1:0]]  <= req_addr;
      r_mem_wdata[r_wr_ptr[PTR_W-1:0]] <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_wait_clr)      r_wait <= '0;
      else if (w_wait_inc) r_wait <= r_wait + 1'b1;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    ctrl_wr_enable = 1'b0;
    ctrl_rd_enable = 1'b0;
    w_pop          = 1'b0;
    w_retry        = 1'b0;
    w_resp_load    = 1'b0;
    w_wait_clr     = 1'b0;
    w_wait_inc     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && (w_head_write || w_resp_free)) w_state_next = S_ISSUE;
      end
      S_ISSUE: begin
        ctrl_wr_enable = w_head_write;
        ctrl_rd_enable = !w_empty && !w_head_write;
        w_wait_clr     = 1'b1;
        w_state_next   = S_ACCEPT;
      end
      S_ACCEPT: begin
        if (ctrl_busy) begin
          w_state_next = S_DONE;
        end else if (r_wait == WAIT_W'(ACCEPT_WAIT - 1)) begin
          w_retry      = 1'b1;
          w_state_next = S_ISSUE;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      S_DONE: begin
        if (w_head_write) begin
          if (!ctrl_busy) begin
            w_pop        = 1'b1;
            w_state_next = S_IDLE;
          end
        end else if (ctrl_rd_ready) begin
          w_pop        = 1'b1;
          w_resp_load  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
    end else if (w_resp_load) begin
      r_resp_valid <= 1'b1;
      r_resp_data  <= ctrl_rd_data;
    end else if (r_resp_valid && resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_retries <= '0;
    end else if (w_retry && (r_retries != 8'hFF)) begin
      r_retries <= r_retries + 1'b1;
    end
  end

endmodule
